// File: rtl/pulp_hwpe_port_ctrl_if.sv
// Per-port TCDM handshake bundle between the HWPE engine, the port controller and the XBAR masters.
// Signal names are taken from the controller's point of view.
interface pulp_hwpe_port_ctrl_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0] acc_req_i;
  logic [N_PORTS-1:0] acc_gnt_o;
  logic [N_PORTS-1:0] acc_rvalid_o;
  logic [N_PORTS-1:0] mst_req_o;
  logic [N_PORTS-1:0] mst_gnt_i;
  logic [N_PORTS-1:0] mst_rvalid_i;

  modport slave (
    input  acc_req_i, mst_gnt_i, mst_rvalid_i,
    output acc_gnt_o, acc_rvalid_o, mst_req_o
  );

  modport master (
    output acc_req_i, mst_gnt_i, mst_rvalid_i,
    input  acc_gnt_o, acc_rvalid_o, mst_req_o
  );
endinterface

// File: rtl/pulp_hwpe_port_ctrl.sv
// TCDM master-port controller: per-port outstanding throttle, drain/quiesce FSM,
// registered busy, registered event forwarding and sticky protocol-error flag.
module pulp_hwpe_port_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic req_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic req_o,
  output logic gnt_o,
  output logic zero_d_o,
  output logic nz_o,
  output logic err_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk, inc;

  assign blk   = (cnt_q == CNT_W'(MAX_OUTST)) | hold_i;
  assign req_o = req_i & ~blk;
  assign inc   = req_o & gnt_i;
  assign gnt_o = inc;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc && !rvalid_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!inc && rvalid_i) begin
      // A response with nothing in flight is a protocol error; never wrap.
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_d_o = (cnt_d == '0);
  assign nz_o     = (cnt_q != '0);
endmodule

module pulp_hwpe_port_ctrl #(
  parameter int N_PORTS   = 4,
  parameter int N_CORES   = 2,
  parameter int N_EVT     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  pulp_hwpe_port_ctrl_if.slave            port,
  input  logic                            acc_busy_i,
  input  logic [N_CORES-1:0][N_EVT-1:0]   evt_i,
  output logic [N_CORES-1:0][N_EVT-1:0]   evt_o,
  input  logic                            drain_i,
  output logic                            drain_done_o,
  output logic                            busy_o,
  output logic                            err_o
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e                          state_q;
  logic                            busy_q, err_q, done_q;
  logic [N_CORES-1:0][N_EVT-1:0]   evt_q;
  logic [N_PORTS-1:0]              zero_d, nz, err_p;
  logic                            hold;

  // Requests are also held off while in reset so nothing is issued to the XBAR.
  assign hold = (state_q != RUN) | rst;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    pulp_hwpe_port_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (hold),
      .req_i    (port.acc_req_i[p]),
      .gnt_i    (port.mst_gnt_i[p]),
      .rvalid_i (port.mst_rvalid_i[p]),
      .req_o    (port.mst_req_o[p]),
      .gnt_o    (port.acc_gnt_o[p]),
      .zero_d_o (zero_d[p]),
      .nz_o     (nz[p]),
      .err_o    (err_p[p])
    );
  end

  assign port.acc_rvalid_o = port.mst_rvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      busy_q <= acc_busy_i | (|nz) | (state_q == DRAIN);
      err_q  <= err_q | (|err_p);
      evt_q  <= evt_i;
      case (state_q)
        RUN: if (drain_i) state_q <= DRAIN;
        // Look at next-cycle counts so the last response completes the drain at once.
        DRAIN: if (&zero_d) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: if (!drain_i) begin
          state_q <= RUN;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign drain_done_o = done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign evt_o        = evt_q;
endmodule

// File: tb/tb_pulp_hwpe_port_ctrl.sv
// Self-checking bench for pulp_hwpe_port_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the port controller.
module tb_pulp_hwpe_port_ctrl;
  localparam int NP = 4;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acc_busy_i = 1'b0;
  logic drain_i = 1'b0;
  logic [1:0][1:0] evt_i = '0;
  logic [1:0][1:0] evt_o;
  logic drain_done_o, busy_o, err_o;

  pulp_hwpe_port_ctrl_if #(.N_PORTS(NP)) bus ();

  pulp_hwpe_port_ctrl #(
    .N_PORTS(NP), .N_CORES(2), .N_EVT(2), .MAX_OUTST(MAX)
  ) dut (
    .clk(clk), .rst(rst), .port(bus), .acc_busy_i(acc_busy_i),
    .evt_i(evt_i), .evt_o(evt_o), .drain_i(drain_i),
    .drain_done_o(drain_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: in-flight counts, mode (0 run, 1 draining, 2 drained), registered outputs.
  int m_cnt [NP];
  int m_mode;
  bit m_busy, m_err;
  logic [1:0][1:0] m_evt;

  function automatic logic [NP-1:0] m_req();
    logic [NP-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++)
      r[p] = !rst && bus.acc_req_i[p] && (m_cnt[p] < MAX) && (m_mode == 0);
    return r;
  endfunction

  task automatic m_tick();
    logic [NP-1:0] r;
    bit any, empty;
    if (rst) begin
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      m_mode = 0; m_busy = 0; m_err = 0; m_evt = '0;
      return;
    end
    r = m_req();
    any = 0;
    for (int p = 0; p < NP; p++) if (m_cnt[p] > 0) any = 1;
    m_busy = acc_busy_i || any || (m_mode == 1);
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = m_cnt[p] + int'(r[p] && bus.mst_gnt_i[p]) - int'(bus.mst_rvalid_i[p]);
      if (m_cnt[p] < 0) begin
        m_cnt[p] = 0;
        m_err = 1;
      end
    end
    empty = 1;
    for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) empty = 0;
    if (m_mode == 0 && drain_i) m_mode = 1;
    else if (m_mode == 1 && empty) m_mode = 2;
    else if (m_mode == 2 && !drain_i) m_mode = 0;
    m_evt = evt_i;
  endtask

  task automatic tick();
    m_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.acc_req_i = '0; bus.mst_gnt_i = '0; bus.mst_rvalid_i = '0;
    acc_busy_i = 0; drain_i = 0; evt_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.acc_req_i = 4'hF;
    acc_busy_i = 1;
    evt_i = 4'hF;
    rst = 1;
    tick();
    tick();
    #1;
    n_chk++;
    if (bus.mst_req_o !== 4'h0 || bus.acc_gnt_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_req got=%h/%h exp=0/0", bus.mst_req_o, bus.acc_gnt_o);
    end
    n_chk++;
    if ({busy_o, err_o, drain_done_o} !== 3'b000 || evt_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_regs got busy=%b err=%b done=%b evt=%h exp=0", busy_o, err_o, drain_done_o, evt_o);
    end
    rst = 0;
    acc_busy_i = 0;
    evt_i = '0;
    tick();
    n_chk++;
    if (bus.mst_req_o !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_req got=%h exp=f", bus.mst_req_o);
    end
    do_reset();
  endtask

  task automatic test_throttle();
    int g;
    do_reset();
    bus.acc_req_i = 4'b0001;
    bus.mst_gnt_i = 4'b0001;
    g = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.acc_gnt_o[0]) g++;
      tick();
    end
    n_chk++;
    if (g != MAX) begin
      n_fail++;
      $display("FAIL throttle_grants got=%0d exp=%0d", g, MAX);
    end
    n_chk++;
    if (bus.mst_req_o[0] !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_block got req=%b busy=%b exp req=0 busy=1", bus.mst_req_o[0], busy_o);
    end
    bus.mst_gnt_i = 4'b0000;
    bus.mst_rvalid_i = 4'b0001;
    tick();
    bus.mst_rvalid_i = 4'b0000;
    #1;
    n_chk++;
    if (bus.mst_req_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_release got=%b exp=1", bus.mst_req_o[0]);
    end
    bus.mst_gnt_i = 4'b0001;
    tick();
    // At the ceiling the first cycle is blocked (response only); afterwards every cycle
    // carries one grant and one response, so the count holds one below the ceiling.
    bus.mst_rvalid_i = 4'b0001;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.acc_gnt_o[0]) g++;
      tick();
    end
    n_chk++;
    if (g != 9 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL incdec_steady got grants=%0d err=%b exp grants=9 err=0", g, err_o);
    end
    bus.acc_req_i = '0;
    bus.mst_gnt_i = '0;
    for (int i = 0; i < 3; i++) tick();
    bus.mst_rvalid_i = '0;
    tick();
    tick();
    n_chk++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_idle got busy=%b err=%b exp 0 0", busy_o, err_o);
    end
  endtask

  task automatic test_drain();
    do_reset();
    bus.acc_req_i = 4'b0100;
    bus.mst_gnt_i = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    bus.mst_gnt_i = 4'b0000;
    drain_i = 1;
    tick();
    n_chk++;
    if (bus.mst_req_o !== 4'b0000 || drain_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_block got req=%h done=%b exp req=0 done=0", bus.mst_req_o, drain_done_o);
    end
    bus.mst_rvalid_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (drain_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_early i=%0d got=%b exp=0", i, drain_done_o);
      end
      tick();
    end
    bus.mst_rvalid_i = 4'b0000;
    n_chk++;
    if (drain_done_o !== 1'b1 || bus.mst_req_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL drain_done got done=%b req=%h exp done=1 req=0", drain_done_o, bus.mst_req_o);
    end
    drain_i = 0;
    tick();
    #1;
    n_chk++;
    if (drain_done_o !== 1'b0 || bus.mst_req_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL drain_resume got done=%b req=%h exp done=0 req=4", drain_done_o, bus.mst_req_o);
    end
    do_reset();
  endtask

  task automatic test_error();
    int g;
    do_reset();
    bus.mst_rvalid_i = 4'b0010;
    tick();
    bus.mst_rvalid_i = 4'b0000;
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got=%b exp=1", err_o);
    end
    // Count must still be zero: a full quota of grants fits before throttling.
    bus.acc_req_i = 4'b0010;
    bus.mst_gnt_i = 4'b0010;
    g = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.acc_gnt_o[1]) g++;
      tick();
    end
    n_chk++;
    if (g != MAX || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_nowrap got grants=%0d err=%b exp grants=%0d err=1", g, err_o, MAX);
    end
    do_reset();
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got=%b exp=0", err_o);
    end
  endtask

  task automatic test_events();
    logic [3:0] seq_in [6];
    logic [3:0] exp_o;
    logic [3:0] prev;
    do_reset();
    // Single pulse on [1][0], then two back-to-back pulses, then a mixed pattern.
    seq_in[0] = 4'b0100; seq_in[1] = 4'b0000; seq_in[2] = 4'b0100;
    seq_in[3] = 4'b0100; seq_in[4] = 4'b1011; seq_in[5] = 4'b0000;
    prev = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      evt_i = seq_in[i];
      tick();
      exp_o = seq_in[i];
      n_chk++;
      if (evt_o !== exp_o) begin
        n_fail++;
        $display("FAIL evt_fwd i=%0d got=%h exp=%h prev=%h", i, evt_o, exp_o, prev);
      end
      prev = exp_o;
    end
    evt_i = '0;
    tick();
    n_chk++;
    if (evt_o !== 4'h0) begin
      n_fail++;
      $display("FAIL evt_clear got=%h exp=0", evt_o);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      bus.acc_req_i = 4'($urandom);
      bus.mst_gnt_i = 4'($urandom);
      for (int p = 0; p < NP; p++)
        bus.mst_rvalid_i[p] = (m_cnt[p] > 0 && $urandom_range(2) == 0) || ($urandom_range(80) == 0);
      if ($urandom_range(24) == 0) drain_i = ~drain_i;
      acc_busy_i = ($urandom_range(3) == 0);
      evt_i = 4'($urandom);
      #1;
      n_chk++;
      if (bus.mst_req_o !== m_req() || bus.acc_gnt_o !== (m_req() & bus.mst_gnt_i) ||
          bus.acc_rvalid_o !== bus.mst_rvalid_i) begin
        n_fail++;
        if (bad++ < 8)
          $display("FAIL rnd_comb cyc=%0d got req=%h gnt=%h rv=%h exp req=%h gnt=%h rv=%h", c,
                   bus.mst_req_o, bus.acc_gnt_o, bus.acc_rvalid_o, m_req(),
                   m_req() & bus.mst_gnt_i, bus.mst_rvalid_i);
      end
      n_chk++;
      if (busy_o !== m_busy || err_o !== m_err || drain_done_o !== (m_mode == 2) || evt_o !== m_evt) begin
        n_fail++;
        if (bad++ < 8)
          $display("FAIL rnd_regs cyc=%0d got busy=%b err=%b done=%b evt=%h exp busy=%b err=%b done=%b evt=%h",
                   c, busy_o, err_o, drain_done_o, evt_o, m_busy, m_err, m_mode == 2, m_evt);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_mode = 0; m_busy = 0; m_err = 0; m_evt = '0;
    test_reset();
    test_throttle();
    test_drain();
    test_error();
    test_events();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
